// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the PA-RISC pipeline control logic.
package cpu_ctrl_pkg;

    localparam int unsigned RD_W = 5;

    localparam logic [1:0] FW_RP  = 2'b00;
    localparam logic [1:0] FW_EX  = 2'b01;
    localparam logic [1:0] FW_MEM = 2'b10;
    localparam logic [1:0] FW_WB  = 2'b11;

    typedef enum logic {
        RUN     = 1'b0,
        NULLIFY = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            we;
        logic            load;
    } sb_entry_t;

    // GR0 is hardwired to zero, so a write to it never produces a usable value
    function automatic logic sb_hit(input sb_entry_t e, input logic [RD_W-1:0] src);
        return e.we && (e.rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority compare of one ID source index against the EX/MEM/WB scoreboard.
module fwd_select
    import cpu_ctrl_pkg::*;
(
    input  logic [RD_W-1:0] src,
    input  logic            used,
    input  sb_entry_t       ex,
    input  sb_entry_t       mem,
    input  sb_entry_t       wb,
    output logic [1:0]      sel_c,
    output logic            load_hit_c
);

    // A load still in EX has no data yet: flag it instead of forwarding older copies
    always_comb begin
        sel_c      = FW_RP;
        load_hit_c = 1'b0;
        if (used) begin
            if (sb_hit(ex, src)) begin
                if (ex.load) begin
                    load_hit_c = 1'b1;
                end else begin
                    sel_c = FW_EX;
                end
            end else if (sb_hit(mem, src)) begin
                sel_c = FW_MEM;
            end else if (sb_hit(wb, src)) begin
                sel_c = FW_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage pipeline controller: scoreboard, forwarding selects, load-use stall,
// taken-branch redirect and delay-slot nullification.
module hazard_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [REG_W-1:0] id_ra,
    input  logic [REG_W-1:0] id_rb,
    input  logic             id_ra_used,
    input  logic             id_rb_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rf_le,
    input  logic             id_load,
    input  logic             id_branch,
    input  logic             id_taken,
    input  logic             id_nullify,
    output logic             pc_le,
    output logic             cu_s,
    output logic             if_s,
    output logic [1:0]       fw_pa_sel,
    output logic [1:0]       fw_pb_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] null_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sb_entry_t        sb_ex;
    sb_entry_t        sb_mem;
    sb_entry_t        sb_wb;
    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic             hit_a;
    logic             hit_b;
    logic             hazard;
    logic             stall_inc;
    logic             null_inc;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] null_q;

    fwd_select u_fwd_a (
        .src        (RD_W'(id_ra)),
        .used       (id_ra_used),
        .ex         (sb_ex),
        .mem        (sb_mem),
        .wb         (sb_wb),
        .sel_c      (sel_a),
        .load_hit_c (hit_a)
    );

    fwd_select u_fwd_b (
        .src        (RD_W'(id_rb)),
        .used       (id_rb_used),
        .ex         (sb_ex),
        .mem        (sb_mem),
        .wb         (sb_wb),
        .sel_c      (sel_b),
        .load_hit_c (hit_b)
    );

    assign hazard = hit_a | hit_b;

    // Scoreboard shift; an injected bubble enters EX as a non-writer
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else begin
            sb_wb     <= sb_mem;
            sb_mem    <= sb_ex;
            sb_ex.rd   <= RD_W'(id_rd);
            sb_ex.we   <= id_rf_le & ~cu_s;
            sb_ex.load <= id_load & ~cu_s;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Control outputs are held at their reset values while Rst is low
    always_comb begin
        state_d   = state_q;
        pc_le     = 1'b1;
        cu_s      = 1'b0;
        if_s      = 1'b0;
        fw_pa_sel = FW_RP;
        fw_pb_sel = FW_RP;
        stall_inc = 1'b0;
        null_inc  = 1'b0;
        if (Rst) begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        pc_le     = 1'b0;
                        cu_s      = 1'b1;
                        stall_inc = 1'b1;
                    end else begin
                        fw_pa_sel = sel_a;
                        fw_pb_sel = sel_b;
                        if (id_branch && id_taken) begin
                            if_s = 1'b1;
                            if (id_nullify) begin
                                state_d = NULLIFY;
                            end
                        end
                    end
                end
                NULLIFY: begin
                    cu_s     = 1'b1;
                    null_inc = 1'b1;
                    state_d  = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating event counters
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_q <= '0;
            null_q  <= '0;
        end else begin
            if (stall_inc && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (null_inc && (null_q != CNT_MAX)) begin
                null_q <= null_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign null_cnt  = null_q;

endmodule
